// File: rtl/bus_arbiter.sv
// Two-master arbiter for the 32-bit CPU memory/IO bus: registered grants, round-robin
// on contention, owner lock, hold-time limit and a one-cycle turnaround between owners.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned HOLD_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_data_out,
    input  logic [3:0]  m0_data_strobes,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic        m0_grant,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_data_out,
    input  logic [3:0]  m1_data_strobes,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic        m1_grant,
    output logic [29:0] bus_address,
    output logic [31:0] bus_data_out,
    output logic [3:0]  bus_data_strobes,
    output logic        bus_read,
    output logic        bus_write,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic                  HOLD_ENABLE = (MAX_HOLD != 32'd0);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT  =
        (MAX_HOLD == 32'd0) ? {HOLD_WIDTH{1'b0}} : HOLD_WIDTH'(MAX_HOLD - 32'd1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE    = HOLD_WIDTH'(32'd1);

    state_t                state_q, state_d;
    logic                  last_owner_q, last_owner_d;
    logic [HOLD_WIDTH-1:0] hold_count_q, hold_count_d;

    // Waiting-cycle counter: counts while the other master waits, saturating at all-ones.
    function automatic logic [HOLD_WIDTH-1:0] hold_next(
        input logic                  other_req,
        input logic [HOLD_WIDTH-1:0] cur
    );
        logic [HOLD_WIDTH-1:0] nxt;
        if (!other_req) begin
            nxt = {HOLD_WIDTH{1'b0}};
        end else if (cur == {HOLD_WIDTH{1'b1}}) begin
            nxt = cur;
        end else begin
            nxt = cur + HOLD_ONE;
        end
        return nxt;
    endfunction

    // State, round-robin history and hold counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_count_q <= {HOLD_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_count_q <= hold_count_d;
        end
    end

    // Next-state logic: arbitration from IDLE/TURN, release decisions while owned.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_count_d = hold_count_q;
        case (state_q)
            IDLE, TURN: begin
                hold_count_d = {HOLD_WIDTH{1'b0}};
                // On contention the master that did not own last wins.
                if (m0_req && m1_req) begin
                    if (last_owner_q) begin
                        state_d      = OWN0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d      = OWN1;
                        last_owner_d = 1'b1;
                    end
                end else if (m0_req) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (m1_req) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                hold_count_d = hold_next(m1_req, hold_count_q);
                if (!m0_req ||
                    (HOLD_ENABLE && m1_req && (hold_count_q >= HOLD_LIMIT) && !m0_lock)) begin
                    state_d = m1_req ? TURN : IDLE;
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                hold_count_d = hold_next(m0_req, hold_count_q);
                if (!m1_req ||
                    (HOLD_ENABLE && m0_req && (hold_count_q >= HOLD_LIMIT) && !m1_lock)) begin
                    state_d = m0_req ? TURN : IDLE;
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d      = IDLE;
                hold_count_d = {HOLD_WIDTH{1'b0}};
            end
        endcase
    end

    assign m0_grant = (state_q == OWN0);
    assign m1_grant = (state_q == OWN1);
    assign busy     = m0_grant | m1_grant;

    // Bus mux driven by the registered owner; no owner means a quiet bus.
    always_comb begin
        bus_address      = 30'd0;
        bus_data_out     = 32'd0;
        bus_data_strobes = 4'd0;
        bus_read         = 1'b0;
        bus_write        = 1'b0;
        case (state_q)
            OWN0: begin
                bus_address      = m0_address;
                bus_data_out     = m0_data_out;
                bus_data_strobes = m0_data_strobes;
                bus_read         = m0_read;
                bus_write        = m0_write;
            end
            OWN1: begin
                bus_address      = m1_address;
                bus_data_out     = m1_data_out;
                bus_data_strobes = m1_data_strobes;
                bus_read         = m1_read;
                bus_write        = m1_write;
            end
            default: begin
                bus_address      = 30'd0;
                bus_data_out     = 32'd0;
                bus_data_strobes = 4'd0;
                bus_read         = 1'b0;
                bus_write        = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, round-robin, hold limit,
// lock, turnaround and asynchronous reset behaviour.
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_lock, m0_read, m0_write;
    logic [29:0] m0_address;
    logic [31:0] m0_data_out;
    logic [3:0]  m0_data_strobes;
    logic        m1_req, m1_lock, m1_read, m1_write;
    logic [29:0] m1_address;
    logic [31:0] m1_data_out;
    logic [3:0]  m1_data_strobes;
    logic        m0_grant, m1_grant;
    logic [29:0] bus_address;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_data_strobes;
    logic        bus_read, bus_write, busy;

    int checks_total  = 0;
    int checks_passed = 0;

    bus_arbiter #(.MAX_HOLD(16), .HOLD_WIDTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .m0_req          (m0_req),
        .m0_lock         (m0_lock),
        .m0_address      (m0_address),
        .m0_data_out     (m0_data_out),
        .m0_data_strobes (m0_data_strobes),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_grant        (m0_grant),
        .m1_req          (m1_req),
        .m1_lock         (m1_lock),
        .m1_address      (m1_address),
        .m1_data_out     (m1_data_out),
        .m1_data_strobes (m1_data_strobes),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_grant        (m1_grant),
        .bus_address     (bus_address),
        .bus_data_out    (bus_data_out),
        .bus_data_strobes(bus_data_strobes),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total = checks_total + 1;
        if (got === exp) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int cycles;
    int lost;

    initial begin
        reset           = 1'b0;
        m0_req          = 1'b1;
        m1_req          = 1'b1;
        m0_lock         = 1'b0;
        m1_lock         = 1'b0;
        m0_address      = 30'h0000_0010;
        m1_address      = 30'h0000_0020;
        m0_data_out     = 32'hDEAD_0000;
        m1_data_out     = 32'hCAFE_0001;
        m0_data_strobes = 4'h3;
        m1_data_strobes = 4'hF;
        m0_read         = 1'b1;
        m0_write        = 1'b0;
        m1_read         = 1'b0;
        m1_write        = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_m0_grant", 64'(m0_grant), 64'd0);
        check_eq("rst_m1_grant", 64'(m1_grant), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_bus_address", 64'(bus_address), 64'd0);
        check_eq("rst_bus_read", 64'(bus_read), 64'd0);

        // Both request out of reset: last_owner resets to 1, so m0 wins first.
        reset = 1'b1;
        tick();
        check_eq("first_m0_grant", 64'(m0_grant), 64'd1);
        check_eq("first_m1_grant", 64'(m1_grant), 64'd0);
        check_eq("first_bus_address", 64'(bus_address), 64'h10);
        check_eq("first_bus_read", 64'(bus_read), 64'd1);
        check_eq("ungranted_write_blocked", 64'(bus_write), 64'd0);
        check_eq("first_strobes", 64'(bus_data_strobes), 64'h3);

        // m1 keeps waiting: m0 is preempted after 16 owned cycles.
        cycles = 0;
        while (m0_grant && cycles < 200) begin
            cycles = cycles + 1;
            tick();
        end
        check_eq("hold_limit_cycles", 64'(cycles), 64'd16);
        check_eq("turn_busy", 64'(busy), 64'd0);
        check_eq("turn_bus_read", 64'(bus_read), 64'd0);
        check_eq("turn_bus_write", 64'(bus_write), 64'd0);
        tick();
        check_eq("after_turn_m1_grant", 64'(m1_grant), 64'd1);
        check_eq("after_turn_bus_address", 64'(bus_address), 64'h20);
        check_eq("after_turn_bus_write", 64'(bus_write), 64'd1);

        repeat (3) tick();
        check_eq("m1_still_owns", 64'(m1_grant), 64'd1);

        // m1 drops req with m0 waiting: TURN, and m1 re-requesting during TURN still loses.
        m1_req = 1'b0;
        tick();
        check_eq("drop_turn_m1_grant", 64'(m1_grant), 64'd0);
        check_eq("drop_turn_m0_grant", 64'(m0_grant), 64'd0);
        m1_req  = 1'b1;
        m0_lock = 1'b1;
        tick();
        check_eq("rr_m0_wins", 64'(m0_grant), 64'd1);
        check_eq("rr_m1_waits", 64'(m1_grant), 64'd0);

        // Lock holds the bus far past the hold limit.
        lost = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (!m0_grant) lost = lost + 1;
        end
        check_eq("lock_no_preempt", 64'(lost), 64'd0);
        m0_lock = 1'b0;
        tick();
        check_eq("unlock_preempt_m0", 64'(m0_grant), 64'd0);
        check_eq("unlock_preempt_busy", 64'(busy), 64'd0);
        tick();
        check_eq("unlock_m1_grant", 64'(m1_grant), 64'd1);

        // Both idle, then m1 alone: one-clock grant latency.
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        check_eq("idle_busy", 64'(busy), 64'd0);
        tick();
        m1_req = 1'b1;
        tick();
        check_eq("solo_m1_grant", 64'(m1_grant), 64'd1);
        check_eq("solo_bus_write", 64'(bus_write), 64'd1);
        check_eq("solo_strobes", 64'(bus_data_strobes), 64'hF);
        check_eq("solo_data", 64'(bus_data_out), 64'hCAFE_0001);
        check_eq("solo_no_m0_read", 64'(bus_read), 64'd0);

        // Reset mid-write drops everything before the next rising edge.
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_m1_grant", 64'(m1_grant), 64'd0);
        check_eq("async_bus_write", 64'(bus_write), 64'd0);
        check_eq("async_busy", 64'(busy), 64'd0);
        check_eq("async_strobes", 64'(bus_data_strobes), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the 32-bit CPU memory/IO bus.
- Master 0 is the maxicore32. Master 1 is a bus-mastering engine, e.g. a level loader copying EEPROM-sourced data into map RAM.
- Registered grants, round-robin on contention, bus locking, hold-time limit, and a mandatory one-cycle turnaround between owners.
- Outputs drive the shared address, data, strobe, read and write lines that feed chip-select decode and the peripherals.

Parameters:
- MAX_HOLD, 16: max consecutive owned cycles while the other master waits; 0 = unlimited.
- HOLD_WIDTH, 8: hold counter width; must satisfy MAX_HOLD < 2**HOLD_WIDTH.

Ports:
- clock  in  1  bus clock (cpu_clock domain)
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 requests the bus
- m0_lock  in  1  master 0 forbids preemption while owning
- m0_address  in  30  master 0 word address [31:2]
- m0_data_out  in  32  master 0 write data
- m0_data_strobes  in  4  master 0 byte strobes
- m0_read  in  1  master 0 read
- m0_write  in  1  master 0 write
- m0_grant  out  1  master 0 owns the bus
- m1_req, m1_lock, m1_address, m1_data_out, m1_data_strobes, m1_read, m1_write, m1_grant: same as m0_*, for master 1
- bus_address  out  30  muxed address
- bus_data_out  out  32  muxed write data
- bus_data_strobes  out  4  muxed strobes
- bus_read  out  1  muxed read
- bus_write  out  1  muxed write
- busy  out  1  any grant active

Behaviour:
- State register: IDLE, OWN0, OWN1, TURN. Also last_owner (1 bit) and hold_count (HOLD_WIDTH bits).
- Reset (reset=0, async): state=IDLE, last_owner=1, hold_count=0. All grants 0, all bus_* outputs 0, busy=0.
- Grants are decoded from the state register only:
  - m0_grant = (state==OWN0); m1_grant = (state==OWN1); busy = m0_grant | m1_grant.
- Bus mux is combinational on the registered state:
  - OWN0 selects m0_*; OWN1 selects m1_*.
  - IDLE and TURN force bus_read=0, bus_write=0, bus_address=0, bus_data_out=0, bus_data_strobes=0.
  - A non-granted master's read/write never reaches the bus.
- IDLE:
  - Only one req set: go to that master's OWN state.
  - Both set: grant the master != last_owner.
  - Neither set: stay in IDLE.
  - Latency from req rising to grant: 1 clock.
- OWNn, on entry: hold_count=0, last_owner=n.
- OWNn, each cycle:
  - If the other master's req=1, hold_count increments, saturating at all-ones; otherwise hold_count=0.
  - Release when mn_req=0, or when all of: MAX_HOLD!=0, other req=1, hold_count>=MAX_HOLD-1, mn_lock=0.
  - Release target: TURN if the other master's req=1, else IDLE.
- mn_lock=1 blocks preemption indefinitely. Dropping mn_req still releases, even with lock high.
- TURN: exactly one cycle with no owner, then re-evaluate as in IDLE.
  - The round-robin rule makes the waiting master win over an immediate re-request from the previous owner.
- A master deasserting req while granted: grant falls on the next edge. A request pulse that lasts only one cycle while the bus is owned is lost; masters hold req until granted.
- Masters must not assert read/write before sampling their own grant=1. Asserting them without a grant is ignored by the arbiter and is not an error.
- Reset asserted mid-transfer: grants and bus strobes drop immediately (async); no transaction completion is guaranteed.

Test Plan:
- Reset with both reqs=1, release reset: cycle 1 m0_grant=1 (last_owner reset=1), bus_address follows m0_address=30'h0000_0010.
- m1 alone requests: m1_req rises at edge k, m1_grant=1 after edge k+1; m1_write=1 with strobes 4'hF appears on bus_write/bus_data_strobes.
- Contention, MAX_HOLD=16, m0 owns, m1_req held: m0_grant drops after 16 waiting cycles, one TURN cycle with bus_read=bus_write=0, then m1_grant=1.
- Same as previous with m0_lock=1: m0 keeps bus for 100+ cycles; drop lock, preemption occurs on the cycle hold_count>=15 is next seen.
- m1 owns, drops req while m0_req=1 → TURN → OWN0; m1 re-raises req during TURN → m0 still wins.
- Assert reset=0 mid-OWN1 write: m1_grant, bus_write, busy go to 0 without waiting for a clock edge.
